word_gearbox: RTL

Parametrised word-width gearbox: accepts IN_WORDS words per input beat and emits OUT_WORDS words per output beat, for any ratio (integer or not), with valid/ready flow control on both sides. It generalises the fixed 5-to-20 and 20-to-5 converters and sits between datapath stages that run at different bus widths. Word order is preserved, and word 0 of every beat is in the least significant bits. An optional packet-boundary mode flushes a partial tail with zero padding.

---
 rtl/word_gearbox_pkg.sv | 20 ++
 rtl/word_shift_buffer.sv | 48 ++++
 rtl/word_gearbox.sv | 96 +++++++++
 3 files changed

// File: rtl/word_gearbox_pkg.sv
// Shared helpers for the word_gearbox slice (clog2, max, buffer-depth check).
// Used by both the default build and the WORD_GEARBOX_LAST_EN build.
package word_gearbox_pkg;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The buffer must hold a residual partial beat plus one full input beat.
  function automatic bit buf_words_ok(input int in_words, input int out_words, input int buf_words);
    return buf_words >= in_words + out_words - 1;
  endfunction

endpackage

// File: rtl/word_shift_buffer.sv
// Word buffer for word_gearbox: write IN_WORDS words at an offset, shift down by
// OUT_WORDS with zero fill. Identical in both WORD_GEARBOX_LAST_EN builds.
module word_shift_buffer
  import word_gearbox_pkg::*;
#(
  parameter int WORD_LEN  = 16,
  parameter int IN_WORDS  = 5,
  parameter int OUT_WORDS = 20,
  parameter int BUF_WORDS = IN_WORDS + OUT_WORDS,
  parameter int PTR_W     = 5
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          shift_en,
  input  logic                          wr_en,
  input  logic [PTR_W-1:0]              wr_pos,
  input  logic [IN_WORDS*WORD_LEN-1:0]  wr_data,
  output logic [OUT_WORDS*WORD_LEN-1:0] rd_data
);

  logic [BUF_WORDS*WORD_LEN-1:0] mem;
  logic [BUF_WORDS*WORD_LEN-1:0] mem_next;

  // Shift first, then land the new beat, so a simultaneous write uses the post-shift offset.
  always_comb begin
    mem_next = shift_en ? (mem >> (OUT_WORDS * WORD_LEN)) : mem;
    if (wr_en) begin
      for (int j = 0; j < IN_WORDS; j++) begin
        for (int i = 0; i < BUF_WORDS; i++) begin
          if (int'(wr_pos) + j == i) begin
            mem_next[i*WORD_LEN +: WORD_LEN] = wr_data[j*WORD_LEN +: WORD_LEN];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem <= '0;
    end else begin
      mem <= mem_next;
    end
  end

  assign rd_data = mem[OUT_WORDS*WORD_LEN-1:0];

endmodule

// File: rtl/word_gearbox.sv
// Parametrised IN_WORDS -> OUT_WORDS word gearbox with valid/ready on both sides.
// Define WORD_GEARBOX_LAST_EN to add din_last/dout_last and zero-padded tail flush.
module word_gearbox
  import word_gearbox_pkg::*;
#(
  parameter int WORD_LEN  = 16,
  parameter int IN_WORDS  = 5,
  parameter int OUT_WORDS = 20,
  parameter int BUF_WORDS = IN_WORDS + OUT_WORDS
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [IN_WORDS*WORD_LEN-1:0]  din,
  input  logic                          din_valid,
  output logic                          din_ready,
`ifdef WORD_GEARBOX_LAST_EN
  input  logic                          din_last,
  output logic                          dout_last,
`endif
  output logic [OUT_WORDS*WORD_LEN-1:0] dout,
  output logic                          dout_valid,
  input  logic                          dout_ready
);

  localparam int CW = max(clog2(BUF_WORDS + 1), 1);
  localparam logic [CW-1:0] IN_C  = CW'(IN_WORDS);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_WORDS);
  localparam logic [CW-1:0] BUF_C = CW'(BUF_WORDS);

  if (!buf_words_ok(IN_WORDS, OUT_WORDS, BUF_WORDS)) begin : g_bad_buf_words
    $error("word_gearbox: BUF_WORDS must be at least IN_WORDS+OUT_WORDS-1");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] wr_pos;
  logic          pend_last;
  logic          final_beat;
  logic          in_fire;
  logic          out_fire;

  // Handshake depends on registered cnt/pend_last only, never on dout_ready.
  assign din_ready  = (cnt <= BUF_C - IN_C) && !pend_last;
  assign dout_valid = (cnt >= OUT_C) || (pend_last && (cnt != '0));
  assign final_beat = pend_last && (cnt != '0) && (cnt <= OUT_C);
  assign in_fire    = din_valid && din_ready;
  assign out_fire   = dout_valid && dout_ready;

  // A flushed tail beat removes fewer than OUT_WORDS real words.
  assign drop     = (cnt >= OUT_C) ? OUT_C : cnt;
  assign wr_pos   = out_fire ? (cnt - drop) : cnt;
  assign cnt_next = cnt - (out_fire ? drop : '0) + (in_fire ? IN_C : '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef WORD_GEARBOX_LAST_EN
  // pend_last blocks input from the last beat until the final (possibly padded) beat leaves.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend_last <= 1'b0;
    end else if (in_fire && din_last) begin
      pend_last <= 1'b1;
    end else if (out_fire && final_beat) begin
      pend_last <= 1'b0;
    end
  end

  assign dout_last = final_beat;
`else
  assign pend_last = 1'b0;
`endif

  word_shift_buffer #(
    .WORD_LEN  (WORD_LEN),
    .IN_WORDS  (IN_WORDS),
    .OUT_WORDS (OUT_WORDS),
    .BUF_WORDS (BUF_WORDS),
    .PTR_W     (CW)
  ) u_buffer (
    .clk      (clk),
    .arst_n   (arst_n),
    .shift_en (out_fire),
    .wr_en    (in_fire),
    .wr_pos   (wr_pos),
    .wr_data  (din),
    .rd_data  (dout)
  );

endmodule
